// File: rtl/mnist_tile_scheduler.sv
// mnist_tile_scheduler: sequences the systolic array through one 1x784 by
// 784x10 inference. It walks the K dimension in tiles of ARRAY_L rows,
// accumulates the per-tile partial sums, and reduces them with an argmax
// into a one-hot class.
module mnist_tile_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_L    = 10,
    parameter int ARRAY_A_L  = 784,
    parameter int ARRAY_W_L  = 10,
    parameter int ACC_WIDTH  = 40,
    parameter int IMAGES     = 10,
    parameter int TIMEOUT    = 1023
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [$clog2(IMAGES)-1:0]                         image_num,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              err,
    output logic [ARRAY_W_L-1:0]                              classes,
    output logic [3:0]                                        class_idx,
    output logic [$clog2(IMAGES)-1:0]                         arr_image_num,
    output logic [$clog2((ARRAY_A_L+ARRAY_L-1)/ARRAY_L)-1:0]  arr_tile_idx,
    output logic [$clog2(ARRAY_L+1)-1:0]                      arr_valid_rows,
    output logic                                              arr_load_w,
    input  logic                                              arr_load_ack,
    output logic                                              arr_start,
    input  logic                                              arr_done,
    input  logic [ARRAY_W_L*2*DATA_WIDTH-1:0]                 arr_psum
);

    localparam int NUM_TILES = (ARRAY_A_L + ARRAY_L - 1) / ARRAY_L;
    localparam int LAST_ROWS = ARRAY_A_L - (NUM_TILES - 1) * ARRAY_L;
    localparam int IW        = $clog2(IMAGES);
    localparam int TW        = $clog2(NUM_TILES);
    localparam int RW        = $clog2(ARRAY_L + 1);
    localparam int CW        = $clog2(ARRAY_W_L);
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int TMW       = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0]        LAST_TILE = TW'(NUM_TILES - 1);
    localparam logic [CW-1:0]        LAST_COL  = CW'(ARRAY_W_L - 1);
    localparam logic [TMW-1:0]       TMR_LAST  = TMW'(TIMEOUT - 1);
    localparam logic [ARRAY_W_L-1:0] ONE_LSB   = ARRAY_W_L'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ACC,
        S_ARGMAX,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           tile_q, tile_d;
    logic [CW-1:0]           col_q, col_d;
    logic [TMW-1:0]          timer_q;
    logic signed [ACC_WIDTH-1:0] acc_q [ARRAY_W_L];
    logic signed [ACC_WIDTH-1:0] best_q, best_d;
    logic [CW-1:0]           best_idx_q, best_idx_d;
    logic [ARRAY_W_L*PW-1:0] psum_q;

    logic                    accept_start;
    logic                    capture;
    logic                    timeout;

    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [ARRAY_W_L-1:0]    classes_q;
    logic [3:0]              class_idx_q;
    logic [IW-1:0]           image_q;
    logic [RW-1:0]           valid_rows_q;
    logic                    load_w_q;
    logic                    arr_start_q;

    // Sign-extend one PW-bit partial-sum column to accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] sext_psum(input logic [PW-1:0] p);
        return {{(ACC_WIDTH - PW){p[PW-1]}}, p};
    endfunction

    // Next-state logic, tile/column stepping and the running argmax.
    always_comb begin
        state_d      = state_q;
        tile_d       = tile_q;
        col_d        = col_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        accept_start = 1'b0;
        capture      = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    tile_d       = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (arr_load_ack) begin
                    state_d = S_RUN;
                end else if (timer_q == TMR_LAST) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                // timer_q == 0 marks the first RUN cycle, where arr_done is ignored.
                if (arr_done && (timer_q != '0)) begin
                    capture = 1'b1;
                    state_d = S_ACC;
                end else if (timer_q == TMR_LAST) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ACC: begin
                if (tile_q == LAST_TILE) begin
                    col_d   = '0;
                    state_d = S_ARGMAX;
                end else begin
                    tile_d  = tile_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_ARGMAX: begin
                // Strict compare keeps the lowest index on ties.
                if ((col_q == '0) || (acc_q[col_q] > best_q)) begin
                    best_d     = acc_q[col_q];
                    best_idx_d = col_q;
                end
                if (col_q == LAST_COL) begin
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with tile/column counters and the per-state timeout timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tile_q  <= '0;
            col_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            col_q   <= col_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if ((state_q == S_LOAD) || (state_q == S_RUN)) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Partial-sum capture, accumulation and argmax tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            psum_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            for (int j = 0; j < ARRAY_W_L; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            if (capture) begin
                psum_q <= arr_psum;
            end
            if (accept_start) begin
                for (int j = 0; j < ARRAY_W_L; j++) begin
                    acc_q[j] <= '0;
                end
            end else if (state_q == S_ACC) begin
                for (int j = 0; j < ARRAY_W_L; j++) begin
                    acc_q[j] <= acc_q[j] + sext_psum(psum_q[j*PW +: PW]);
                end
            end
        end
    end

    // Registered outputs, derived from the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            classes_q    <= '0;
            class_idx_q  <= '0;
            image_q      <= '0;
            valid_rows_q <= '0;
            load_w_q     <= 1'b0;
            arr_start_q  <= 1'b0;
        end else begin
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            load_w_q    <= (state_d == S_LOAD);
            arr_start_q <= (state_d == S_RUN) && (state_q != S_RUN);
            if (state_d == S_LOAD) begin
                valid_rows_q <= (tile_d == LAST_TILE) ? RW'(LAST_ROWS) : RW'(ARRAY_L);
            end
            if (accept_start) begin
                image_q     <= image_num;
                err_q       <= 1'b0;
                classes_q   <= '0;
                class_idx_q <= '0;
            end else if (timeout) begin
                err_q       <= 1'b1;
                classes_q   <= '0;
                class_idx_q <= '0;
            end else if ((state_q == S_ARGMAX) && (state_d == S_DONE)) begin
                classes_q   <= ONE_LSB << best_idx_d;
                class_idx_q <= 4'(best_idx_d);
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign classes        = classes_q;
    assign class_idx      = class_idx_q;
    assign arr_image_num  = image_q;
    assign arr_tile_idx   = tile_q;
    assign arr_valid_rows = valid_rows_q;
    assign arr_load_w     = load_w_q;
    assign arr_start      = arr_start_q;

endmodule

// File: tb/tb_mnist_tile_scheduler.sv
// Bench for mnist_tile_scheduler: a behavioural array model with random
// handshake delays feeds per-tile partial sums; expected class, latency and
// timeout timing come from plain arithmetic over the same stimulus tables.
module tb_mnist_tile_scheduler;

    localparam int DW   = 16;
    localparam int AL   = 10;
    localparam int AAL  = 784;
    localparam int AWL  = 10;
    localparam int TO   = 1023;
    localparam int NT   = (AAL + AL - 1) / AL;
    localparam int LR   = AAL - (NT - 1) * AL;
    localparam int PW   = 2 * DW;
    localparam int LIMIT = 6000;

    logic                clk;
    logic                reset;
    logic                start;
    logic [3:0]          image_num;
    logic                busy;
    logic                done;
    logic                err;
    logic [AWL-1:0]      classes;
    logic [3:0]          class_idx;
    logic [3:0]          arr_image_num;
    logic [6:0]          arr_tile_idx;
    logic [3:0]          arr_valid_rows;
    logic                arr_load_w;
    logic                arr_load_ack;
    logic                arr_start;
    logic                arr_done;
    logic [AWL*PW-1:0]   arr_psum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int psum_tab [NT][AWL];
    int ld_d [NT];
    int rd_d [NT];

    mnist_tile_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .image_num      (image_num),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .classes        (classes),
        .class_idx      (class_idx),
        .arr_image_num  (arr_image_num),
        .arr_tile_idx   (arr_tile_idx),
        .arr_valid_rows (arr_valid_rows),
        .arr_load_w     (arr_load_w),
        .arr_load_ack   (arr_load_ack),
        .arr_start      (arr_start),
        .arr_done       (arr_done),
        .arr_psum       (arr_psum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One inference: mode selects the psum pattern (0 nominal, 1 tie, 2 signed, 3 random).
    task automatic run_inf(input string tag, input int img, input int mode, input bit best,
                           input int hang_tile, input int abort_tile, input bit noise);
        longint sum [AWL];
        logic [AWL-1:0] exp_one;
        int exp_idx, exp_lat, e_cyc, r_cyc;
        int m_tile, ld_cnt, rcnt, run_tile, starts, ti, n;
        bit running, finished, aborted;

        for (int t = 0; t < NT; t++) begin
            for (int j = 0; j < AWL; j++) begin
                case (mode)
                    0: psum_tab[t][j] = (j == 7) ? 5 : 1;
                    1: psum_tab[t][j] = ((j == 2) || (j == 5)) ? 3 : -2;
                    2: psum_tab[t][j] = (j == 3) ? 0 : -1;
                    default: psum_tab[t][j] = int'($urandom);
                endcase
            end
            ld_d[t] = best ? 0 : int'($urandom_range(0, 3));
            rd_d[t] = best ? 1 : int'($urandom_range(1, 4));
        end
        for (int j = 0; j < AWL; j++) begin
            sum[j] = 0;
            for (int t = 0; t < NT; t++) sum[j] += longint'(psum_tab[t][j]);
        end
        exp_idx = 0;
        for (int j = 1; j < AWL; j++) if (sum[j] > sum[exp_idx]) exp_idx = j;
        exp_one = '0;
        exp_one[exp_idx] = 1'b1;
        exp_lat = AWL + 1;
        for (int t = 0; t < NT; t++) exp_lat += ld_d[t] + rd_d[t] + 3;

        image_num = 4'(img);
        start = 1'b1;
        e_cyc = cyc;
        tick();
        start = 1'b0;
        check_eq({tag, "_load_vis"}, 64'({busy, arr_load_w}), 64'(2'b11));
        check_eq({tag, "_clr"}, 64'({err, classes, class_idx}), 64'(0));

        m_tile = 0; ld_cnt = 0; rcnt = 0; run_tile = 0; starts = 0; r_cyc = 0;
        running = 0; finished = 0; aborted = 0; n = 0;
        while (!finished && n < LIMIT) begin
            n++;
            arr_load_ack = 1'b0;
            arr_done     = 1'b0;
            start = noise && busy && ($urandom_range(0, 5) == 0);
            if (start) image_num = 4'($urandom_range(0, 9));
            if (done) begin
                finished = 1;
                if (hang_tile >= 0) begin
                    check_eq({tag, "_to_cyc"}, 64'(cyc - r_cyc), 64'(TO));
                    check_eq({tag, "_to_err"}, 64'(err), 64'(1));
                    check_eq({tag, "_to_cls"}, 64'({classes, class_idx}), 64'(0));
                end else begin
                    check_eq({tag, "_lat"}, 64'(cyc - e_cyc), 64'(exp_lat));
                    check_eq({tag, "_classes"}, 64'(classes), 64'(exp_one));
                    check_eq({tag, "_idx"}, 64'(class_idx), 64'(exp_idx));
                    check_eq({tag, "_err"}, 64'(err), 64'(0));
                    check_eq({tag, "_starts"}, 64'(starts), 64'(NT));
                end
                check_eq({tag, "_img"}, 64'(arr_image_num), 64'(img));
            end else begin
                if (arr_load_w) begin
                    ti = (m_tile < NT) ? m_tile : NT - 1;
                    if (ld_cnt == 0) begin
                        check_eq({tag, "_tile"}, 64'(arr_tile_idx), 64'(m_tile));
                        check_eq({tag, "_rows"}, 64'(arr_valid_rows),
                                 64'((m_tile == NT - 1) ? LR : AL));
                    end
                    if (ld_cnt == ld_d[ti]) begin
                        arr_load_ack = 1'b1;
                        ld_cnt = 0;
                        m_tile++;
                    end else begin
                        ld_cnt++;
                    end
                    if (noise && ($urandom_range(0, 2) == 0)) begin
                        arr_done = 1'b1;
                        arr_psum = {AWL{32'h7fff_0000}};
                    end
                end
                if (arr_start) begin
                    starts++;
                    running  = 1;
                    rcnt     = 0;
                    run_tile = (m_tile > 0) ? m_tile - 1 : 0;
                    r_cyc    = cyc;
                    if (run_tile == abort_tile) begin
                        reset = 1'b1;
                        tick();
                        reset = 1'b0;
                        check_eq({tag, "_rst_busy"}, 64'({busy, done, arr_load_w, arr_start}), 64'(0));
                        check_eq({tag, "_rst_cls"}, 64'({err, classes, class_idx}), 64'(0));
                        finished = 1;
                        aborted  = 1;
                    end else if (noise && ($urandom_range(0, 1) == 0)) begin
                        arr_done = 1'b1;
                        arr_psum = {AWL{32'h4000_0000}};
                    end
                end else if (running) begin
                    rcnt++;
                    ti = (run_tile < NT) ? run_tile : NT - 1;
                    if (rcnt == rd_d[ti] && run_tile != hang_tile) begin
                        arr_done = 1'b1;
                        for (int j = 0; j < AWL; j++) arr_psum[j*PW +: PW] = psum_tab[ti][j];
                        running = 0;
                    end
                end
            end
            if (!finished) tick();
        end
        arr_load_ack = 1'b0;
        arr_done     = 1'b0;
        start        = 1'b0;
        if (!finished) begin
            check_eq({tag, "_wait_done"}, 64'(0), 64'(1));
        end else if (!aborted) begin
            tick();
            check_eq({tag, "_post"}, 64'({busy, done}), 64'(0));
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b1;
        image_num    = 4'd5;
        arr_load_ack = 1'b0;
        arr_done     = 1'b0;
        arr_psum     = '0;

        repeat (4) tick();
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        check_eq("rst_classes", 64'(classes), 64'(0));
        check_eq("rst_idx", 64'(class_idx), 64'(0));
        check_eq("rst_load_w", 64'(arr_load_w), 64'(0));
        check_eq("rst_arr_start", 64'(arr_start), 64'(0));
        check_eq("rst_tile", 64'(arr_tile_idx), 64'(0));
        check_eq("rst_rows", 64'(arr_valid_rows), 64'(0));
        check_eq("rst_img", 64'(arr_image_num), 64'(0));
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check_eq("idle_quiet", 64'({busy, arr_load_w}), 64'(0));

        run_inf("nominal", 1, 0, 1'b1, -1, -1, 1'b0);
        run_inf("tie", 2, 1, 1'b1, -1, -1, 1'b0);
        run_inf("signed", 3, 2, 1'b1, -1, -1, 1'b0);
        run_inf("timeout", 4, 0, 1'b1, 5, -1, 1'b0);
        run_inf("after_to", 6, 3, 1'b0, -1, -1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_inf($sformatf("b2b%0d", i), i, 3, 1'b0, -1, -1, 1'b1);
        end
        run_inf("abort", 2, 0, 1'b1, -1, 40, 1'b0);
        run_inf("fresh", 8, 0, 1'b1, -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
